// File: rtl/omega_network_reverse_ff_pkg.sv
// ============================================================================
// Package : omega_pkg
// Shared helpers for the forward/reverse omega networks: log2, stage count
// derivation and the valid-tagged port word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package omega_pkg;

  localparam int OMEGA_DEFAULT_WIDTH = 8;

  // Bit 0 is the valid tag; the payload sits above it.
  typedef logic [OMEGA_DEFAULT_WIDTH:0] omega_word_t;

  // Number of bits needed to represent value (log2(7) = 3, log2(1) = 1).
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

  function automatic int stage_count(input int ports);
    return log2(ports - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/omega_network_reverse_ff_switch.sv
// ============================================================================
// Module  : reverse_switch_ff
// Registered 2x2 switch; optional hold input under OMEGA_REVERSE_STALL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reverse_switch_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef OMEGA_REVERSE_STALL_EN
  input  logic             stall,
`endif
  input  logic             sel,
  input  logic [WIDTH:0]   in_lo,
  input  logic [WIDTH:0]   in_hi,
  output logic [WIDTH:0]   out_lo,
  output logic [WIDTH:0]   out_hi
);

  logic [WIDTH:0] out_lo_d, out_lo_q;
  logic [WIDTH:0] out_hi_d, out_hi_q;

  always_comb begin
    out_lo_d = sel ? in_hi : in_lo;
    out_hi_d = sel ? in_lo : in_hi;
`ifdef OMEGA_REVERSE_STALL_EN
    if (stall) begin
      out_lo_d = out_lo_q;
      out_hi_d = out_hi_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
    end else begin
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
    end
  end

  assign out_lo = out_lo_q;
  assign out_hi = out_hi_q;

endmodule

`default_nettype wire

// File: rtl/omega_network_reverse_ff.sv
// ============================================================================
// Module  : omega_network_reverse_ff
// Pipelined reverse omega network: out[i] = in[i ^ control], one registered
// switch stage per control bit. Optional stall: OMEGA_REVERSE_STALL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module omega_network_reverse_ff
  import omega_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int IN_PORTS         = 8,
  parameter int OUT_PORTS        = IN_PORTS,
  parameter int ADDR_WIDTH_PORTS = stage_count(OUT_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [0:IN_PORTS-1]           push,
  input  logic [IN_PORTS*WIDTH-1:0]     d_in,
  input  logic [ADDR_WIDTH_PORTS-1:0]   control,
`ifdef OMEGA_REVERSE_STALL_EN
  input  logic                          stall,
`endif
  output logic [0:OUT_PORTS-1]          valid,
  output logic [OUT_PORTS*WIDTH-1:0]    d_out,
  output logic [ADDR_WIDTH_PORTS-1:0]   control_out
);

  localparam int HALF = IN_PORTS / 2;

  // lane[s] is the input of stage s; lane[ADDR_WIDTH_PORTS] is the output.
  logic [WIDTH:0] lane [0:ADDR_WIDTH_PORTS][0:IN_PORTS-1];

  logic [ADDR_WIDTH_PORTS-1:0] ctrl_d [0:ADDR_WIDTH_PORTS-1];
  logic [ADDR_WIDTH_PORTS-1:0] ctrl_q [0:ADDR_WIDTH_PORTS-1];

  generate
    for (genvar g = 0; g < IN_PORTS; g++) begin : g_in
      assign lane[0][g] = {d_in[(g+1)*WIDTH-1 -: WIDTH], push[g]};
    end
  endgenerate

  // Each wavefront carries its own control so back-to-back keys never mix.
  always_comb begin
    ctrl_d[0] = control;
    for (int s = 1; s < ADDR_WIDTH_PORTS; s++) begin
      ctrl_d[s] = ctrl_q[s-1];
    end
`ifdef OMEGA_REVERSE_STALL_EN
    if (stall) begin
      for (int s = 0; s < ADDR_WIDTH_PORTS; s++) begin
        ctrl_d[s] = ctrl_q[s];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < ADDR_WIDTH_PORTS; s++) begin
        ctrl_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < ADDR_WIDTH_PORTS; s++) begin
        ctrl_q[s] <= ctrl_d[s];
      end
    end
  end

  generate
    for (genvar s = 0; s < ADDR_WIDTH_PORTS; s++) begin : g_stage
      logic stage_sel;
      if (s == 0) begin : g_sel_live
        assign stage_sel = control[0];
      end else begin : g_sel_piped
        assign stage_sel = ctrl_q[s-1][s];
      end

      for (genvar g = 0; g < HALF; g++) begin : g_sw
        reverse_switch_ff #(
          .WIDTH (WIDTH)
        ) u_switch (
          .clk    (clk),
          .rst    (rst),
`ifdef OMEGA_REVERSE_STALL_EN
          .stall  (stall),
`endif
          .sel    (stage_sel),
          .in_lo  (lane[s][2*g]),
          .in_hi  (lane[s][2*g+1]),
          .out_lo (lane[s+1][g]),
          .out_hi (lane[s+1][g+HALF])
        );
      end
    end

    for (genvar i = 0; i < OUT_PORTS; i++) begin : g_out
      assign valid[i]                       = lane[ADDR_WIDTH_PORTS][i][0];
      assign d_out[(i+1)*WIDTH-1 -: WIDTH]  = lane[ADDR_WIDTH_PORTS][i][WIDTH:1];
    end
  endgenerate

  assign control_out = ctrl_q[ADDR_WIDTH_PORTS-1];

endmodule

`default_nettype wire

// File: tb/tb_omega_network_reverse_ff.sv
// ============================================================================
// Module  : tb_omega_network_reverse_ff
// Directed, table-driven bench for omega_network_reverse_ff (N=8, W=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_omega_network_reverse_ff;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int NV = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:N-1]      push;
  logic [N*W-1:0]    d_in;
  logic [AW-1:0]     control;
`ifdef OMEGA_REVERSE_STALL_EN
  logic              stall;
`endif
  logic [0:N-1]      valid;
  logic [N*W-1:0]    d_out;
  logic [AW-1:0]     control_out;

  typedef struct {
    logic [0:N-1]   push;
    logic [N*W-1:0] d_in;
    logic [AW-1:0]  ctrl;
    logic [0:N-1]   exp_valid;
    logic [N*W-1:0] exp_dout;
  } vec_t;

  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;

  omega_network_reverse_ff #(
    .WIDTH    (W),
    .IN_PORTS (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .d_in        (d_in),
    .control     (control),
`ifdef OMEGA_REVERSE_STALL_EN
    .stall       (stall),
`endif
    .valid       (valid),
    .d_out       (d_out),
    .control_out (control_out)
  );

  always #5 clk = ~clk;

  function automatic logic [0:N-1] perm_valid(input logic [0:N-1] p, input logic [AW-1:0] c);
    logic [0:N-1] r;
    for (int i = 0; i < N; i++) r[i] = p[i ^ int'(c)];
    return r;
  endfunction

  function automatic logic [N*W-1:0] perm_data(input logic [N*W-1:0] d, input logic [AW-1:0] c);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) begin
      int j;
      j = i ^ int'(c);
      r[(i+1)*W-1 -: W] = d[(j+1)*W-1 -: W];
    end
    return r;
  endfunction

  task automatic drive(input logic [0:N-1] p, input logic [N*W-1:0] d, input logic [AW-1:0] c);
    push    = p;
    d_in    = d;
    control = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [0:N-1] ev,
                       input logic [N*W-1:0] ed, input logic [AW-1:0] ec);
    tests++;
    if (valid !== ev) begin
      fails++;
      $display("FAIL %s valid: got %b want %b", name, valid, ev);
    end
    tests++;
    if (d_out !== ed) begin
      fails++;
      $display("FAIL %s d_out: got %h want %h", name, d_out, ed);
    end
    tests++;
    if (control_out !== ec) begin
      fails++;
      $display("FAIL %s control_out: got %0d want %0d", name, control_out, ec);
    end
  endtask

  initial begin
    // Hand-computed vectors first, then one wavefront per control value.
    vecs[0] = '{8'hFF, 64'h1716151413121110, 3'd0, 8'hFF, 64'h1716151413121110};
    vecs[1] = '{8'b0010_0000, 64'h0000000000A50000, 3'd5, 8'b0000_0001, 64'hA500000000000000};
    vecs[2] = '{8'b1000_0000, 64'h000000000000003C, 3'd7, 8'b0000_0001, 64'h3C00000000000000};
    for (int c = 0; c < 8; c++) begin
      logic [0:N-1]   p;
      logic [N*W-1:0] d;
      for (int g = 0; g < N; g++) begin
        p[g] = ((g + c) % 3) != 0;
        d[(g+1)*W-1 -: W] = 8'(c * 16 + g);
      end
      vecs[3+c] = '{p, d, 3'(c), perm_valid(p, 3'(c)), perm_data(d, 3'(c))};
    end

`ifdef OMEGA_REVERSE_STALL_EN
    stall = 1'b0;
`endif
    rst = 1'b1;
    drive(8'hFF, 64'hDEADBEEFCAFEF00D, 3'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_hold", 8'h00, '0, 3'd0);
    end
    rst = 1'b0;
    drive(8'h00, '0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_reset", 8'h00, '0, 3'd0);
    end

    // Back-to-back wavefronts; outputs lag inputs by AW-1 sampled edges.
    for (int k = 0; k < NV + AW - 1; k++) begin
      if (k < NV) drive(vecs[k].push, vecs[k].d_in, vecs[k].ctrl);
      else        drive(8'h00, '0, 3'd0);
      tick();
      if (k >= AW - 1) begin
        check($sformatf("vec%0d", k - (AW - 1)), vecs[k-(AW-1)].exp_valid,
              vecs[k-(AW-1)].exp_dout, vecs[k-(AW-1)].ctrl);
      end
    end
    drive(8'h00, '0, 3'd0);
    repeat (AW) tick();

    // Reset while two wavefronts are still inside the pipeline.
    drive(8'hFF, 64'h1111111111111111, 3'd2);
    tick();
    drive(8'hFF, 64'h2222222222222222, 3'd4);
    tick();
    rst = 1'b1;
    drive(8'hFF, 64'h3333333333333333, 3'd6);
    tick();
    check("midflight_rst", 8'h00, '0, 3'd0);
    rst = 1'b0;
    drive(8'h00, '0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midflight_drain", 8'h00, '0, 3'd0);
    end

`ifdef OMEGA_REVERSE_STALL_EN
    begin
      logic [0:N-1]   sp [3];
      logic [N*W-1:0] sd [3];
      logic [AW-1:0]  sc [3];
      sp[0] = 8'b1100_0000; sd[0] = 64'h0102030405060708; sc[0] = 3'd1;
      sp[1] = 8'b0000_0011; sd[1] = 64'h1112131415161718; sc[1] = 3'd3;
      sp[2] = 8'b1010_0101; sd[2] = 64'h2122232425262728; sc[2] = 3'd6;
      for (int k = 0; k < 3; k++) begin
        drive(sp[k], sd[k], sc[k]);
        tick();
      end
      check("stall_pre", perm_valid(sp[0], sc[0]), perm_data(sd[0], sc[0]), sc[0]);
      stall = 1'b1;
      drive(8'hFF, 64'hEEEEEEEEEEEEEEEE, 3'd5);
      for (int k = 0; k < 2; k++) begin
        tick();
        check("stall_hold", perm_valid(sp[0], sc[0]), perm_data(sd[0], sc[0]), sc[0]);
      end
      stall = 1'b0;
      drive(8'h00, '0, 3'd0);
      tick();
      check("stall_wf2", perm_valid(sp[1], sc[1]), perm_data(sd[1], sc[1]), sc[1]);
      tick();
      check("stall_wf3", perm_valid(sp[2], sc[2]), perm_data(sd[2], sc[2]), sc[2]);
      for (int k = 0; k < 2; k++) begin
        tick();
        check("stall_dropped", 8'h00, '0, 3'd0);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/omega_network_reverse_ff.md
# omega_network_reverse_ff

Pipelined reverse (unshuffle) omega network that carries responses from the output ports of the forward omega fabric back to the requesting input ports. Each cycle it accepts up to IN_PORTS tagged words and applies the permutation out[i] = in[i ^ control] through log2(IN_PORTS) registered 2x2 switch stages. Each stage registers its own copy of the routing control, so control may change every cycle. It sits on the return path of the multistage interconnect, mirroring the forward network's port ordering and valid/data packing.

## Interface
- WIDTH, 8, payload bits per port
- IN_PORTS, 8, port count; power of two, >= 2
- OUT_PORTS, IN_PORTS, must equal IN_PORTS
- ADDR_WIDTH_PORTS, log2(OUT_PORTS-1), stage count and control width

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- push  in  [0:IN_PORTS-1]  per-port valid for d_in
- d_in  in  IN_PORTS*WIDTH  port g occupies bits [(g+1)*WIDTH-1 -: WIDTH]
- control  in  ADDR_WIDTH_PORTS  XOR routing key for this cycle's wavefront
- stall  in  1  pipeline freeze; present only with OMEGA_REVERSE_STALL_EN
- valid  out  [0:OUT_PORTS-1]  per-port valid for d_out
- d_out  out  OUT_PORTS*WIDTH  same packing as d_in
- control_out  out  ADDR_WIDTH_PORTS  control value of the wavefront currently at the outputs

## Operation
- Stage s (0..ADDR_WIDTH_PORTS-1): switch g (0..IN_PORTS/2-1) takes inputs 2g and 2g+1 and drives outputs g and g+IN_PORTS/2 of the stage register.
- Switch select is bit s of that wavefront's control. Stage 0 uses the LSB.
- Select 0: straight (2g->g, 2g+1->g+N/2). Select 1: crossed.
- The valid bit travels with the data as bit 0 of a WIDTH+1 word. Invalid slots still move and keep their data; there are no collisions, since the mapping is a permutation.
- Control pipeline: a ctrl register per stage, shifted alongside the data. Stage s uses the control latched with its wavefront, not the live input.
- Net function: after ADDR_WIDTH_PORTS cycles, valid[i] = push[i ^ c] and d_out[i] = d_in[i ^ c], where c is the control sampled with that wavefront. control_out = c.
- Reset: every valid register and valid output goes to 0. Data and ctrl registers go to 0, so d_out = 0 and control_out = 0. A reset asserted mid-flight discards all wavefronts; push in the reset cycle is ignored.

## Timing
- Latency is exactly ADDR_WIDTH_PORTS cycles: inputs at edge k appear at outputs after edge k+ADDR_WIDTH_PORTS-1 (3 for N=8).
- Throughput is one wavefront per cycle. There is no input backpressure without the macro.
- Outputs come directly from the final stage registers, with no combinational path from inputs.
- Different control values on back-to-back cycles must not interfere.

## Configuration
- OMEGA_REVERSE_STALL_EN defined:
  - stall=1 holds every stage register, including valid and ctrl. Inputs in that cycle are dropped.
  - Outputs repeat the held wavefront, so the consumer must qualify with its own stall.
  - rst overrides stall.
- OMEGA_REVERSE_STALL_EN undefined: no stall port; the pipeline advances every cycle.

## Structure
- Shared package omega_pkg holds: the log2 function, the stage-count localparam derivation, and a typedef for the WIDTH+1 tagged word used by the forward and reverse networks.
- One sub-module, reverse_switch_ff: a 2x2 registered switch with a sync reset that clears the valid bit, plus a stall input under the macro.
- The top level instantiates IN_PORTS/2 x ADDR_WIDTH_PORTS switches plus the ctrl shift registers.

## Test plan
All scenarios use N=8, W=8.
- Reset: hold rst=1 with push=8'hFF. Then valid=0, d_out=0, control_out=0, both during reset and for 3 cycles after release.
- Identity: push all ports, d_in[g]=g+8'h10, control=0. Three cycles later d_out[g]=g+8'h10, all valid, control_out=0.
- XOR: control=3'b101, single push on port 2 with 8'hA5. Three cycles later only valid[7]=1, d_out[7]=8'hA5.
- Back-to-back: send control 0..7 on consecutive cycles, each with a unique pattern. Each output wavefront matches i^c with no cross-contamination, and control_out tracks 0..7.
- Reset mid-flight: push 2 wavefronts, then assert rst for 1 cycle before they exit. No valid ever rises for them.
- Stall (macro on): stall for 2 cycles with 3 wavefronts in flight. Outputs hold; after release the wavefronts emerge in order, and the inputs presented during the stall never appear.
